// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the two-port line arbiter.
// slave: the arbiter's view; master: the requesters plus memory controller driving it.
interface mem_bus_arbiter_if #(
    parameter int LINE_ADDR_W = 15,
    parameter int DATA_W      = 16
);
    logic [1:0]               req;
    logic [1:0]               req_we;
    logic [2*LINE_ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0]      req_wdata;
    logic [1:0]               gnt;
    logic [1:0]               wbeat_ack;
    logic [1:0]               rvalid;
    logic [DATA_W-1:0]        rdata;
    logic [1:0]               done;

    logic                     m_cmd_valid;
    logic                     m_cmd_we;
    logic [LINE_ADDR_W-1:0]   m_cmd_addr;
    logic                     m_cmd_ready;
    logic                     m_wvalid;
    logic [DATA_W-1:0]        m_wdata;
    logic                     m_wready;
    logic                     m_rvalid;
    logic [DATA_W-1:0]        m_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, wbeat_ack, rvalid, rdata, done,
        output m_cmd_valid, m_cmd_we, m_cmd_addr, m_wvalid, m_wdata,
        input  m_cmd_ready, m_wready, m_rvalid, m_rdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, wbeat_ack, rvalid, rdata, done,
        input  m_cmd_valid, m_cmd_we, m_cmd_addr, m_wvalid, m_wdata,
        output m_cmd_ready, m_wready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for two cache requesters sharing one memory port, one full line burst per grant.
// Latency: grant one cycle after the IDLE sample; read beats reach the requester one cycle after m_rvalid.
// Backpressure: low m_cmd_ready / m_wready / m_rvalid hold the sequencer in place indefinitely.
module mem_bus_arbiter #(
    parameter int LINE_ADDR_W = 15,
    parameter int DATA_W      = 16,
    parameter int BEATS       = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    mem_bus_arbiter_if.slave bus
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic                   win;
        logic                   we;
        logic [LINE_ADDR_W-1:0] addr;
    } txn_t;

    state_t              state_q, state_d;
    txn_t                txn_q;
    logic                last_grant_q;
    logic [CNT_W-1:0]    beat_q;
    logic [1:0]          rvalid_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                any_req;
    logic                win_d;
    logic [1:0]          win_oh;
    logic                last_beat;
    logic                cmd_acc;
    logic                wbeat_acc;
    logic                rbeat_acc;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        any_req = |bus.req;
        win_d   = 1'b0;
        if (bus.req == 2'b10) begin
            win_d = 1'b1;
        end else if (bus.req == 2'b11) begin
            win_d = ~last_grant_q;
        end
    end

    always_comb begin
        win_oh    = txn_q.win ? 2'b10 : 2'b01;
        last_beat = (beat_q == LAST_BEAT);
        cmd_acc   = (state_q == CMD)   && bus.m_cmd_ready;
        wbeat_acc = (state_q == WDATA) && bus.m_wready;
        rbeat_acc = (state_q == RDATA) && bus.m_rvalid;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = CMD;
            CMD:     if (cmd_acc) state_d = txn_q.we ? WDATA : RDATA;
            WDATA:   if (wbeat_acc && last_beat) state_d = DONE;
            RDATA:   if (rbeat_acc && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command is captured once in IDLE; later changes on req_we/req_addr are ignored.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            txn_q        <= '0;
            last_grant_q <= 1'b1;
            beat_q       <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
        end else begin
            rvalid_q <= '0;
            if ((state_q == IDLE) && any_req) begin
                txn_q.win    <= win_d;
                txn_q.we     <= win_d ? bus.req_we[1] : bus.req_we[0];
                txn_q.addr   <= win_d ? bus.req_addr[2*LINE_ADDR_W-1:LINE_ADDR_W]
                                      : bus.req_addr[LINE_ADDR_W-1:0];
                last_grant_q <= win_d;
            end
            if (cmd_acc) begin
                beat_q <= '0;
            end else if (wbeat_acc || rbeat_acc) begin
                beat_q <= beat_q + 1'b1;
            end
            if (rbeat_acc) begin
                rvalid_q <= win_oh;
                rdata_q  <= bus.m_rdata;
            end
        end
    end

    always_comb begin
        bus.gnt         = (state_q != IDLE) ? win_oh : 2'b00;
        bus.done        = (state_q == DONE) ? win_oh : 2'b00;
        bus.rvalid      = rvalid_q;
        bus.rdata       = rdata_q;
        bus.m_cmd_valid = (state_q == CMD);
        bus.m_cmd_we    = (state_q == CMD) && txn_q.we;
        bus.m_cmd_addr  = (state_q == CMD) ? txn_q.addr : '0;
        bus.m_wvalid    = (state_q == WDATA);
        bus.m_wdata     = '0;
        bus.wbeat_ack   = 2'b00;
        if (state_q == WDATA) begin
            bus.m_wdata = txn_q.win ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                    : bus.req_wdata[DATA_W-1:0];
            if (bus.m_wready) begin
                bus.wbeat_ack = win_oh;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
    localparam int LAW   = 15;
    localparam int DW    = 16;
    localparam int BEATS = 8;

    logic CLK = 1'b0;
    logic RESET;
    int   vectors     = 0;
    int   miscompares = 0;

    mem_bus_arbiter_if #(.LINE_ADDR_W(LAW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(.LINE_ADDR_W(LAW), .DATA_W(DW), .BEATS(BEATS)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic to_next();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_quiet();
        bus.req         = '0;
        bus.req_we      = '0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.m_cmd_ready = 1'b0;
        bus.m_wready    = 1'b0;
        bus.m_rvalid    = 1'b0;
        bus.m_rdata     = '0;
    endtask

    task automatic apply_reset();
        drive_quiet();
        RESET = 1'b1;
        @(negedge CLK);
        to_next();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.req = 2'b11; bus.req_we = 2'b11; bus.req_addr = '1; bus.req_wdata = '1;
        bus.m_cmd_ready = 1'b1; bus.m_wready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 16'hBEEF;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            vectors++; if ({bus.gnt, bus.done, bus.rvalid, bus.wbeat_ack} !== 8'h00) begin miscompares++; $display("FAIL rst_strobes: got %b want 00000000", {bus.gnt, bus.done, bus.rvalid, bus.wbeat_ack}); end
            vectors++; if ({bus.m_cmd_valid, bus.m_cmd_we, bus.m_wvalid} !== 3'b000) begin miscompares++; $display("FAIL rst_mem_ctrl: got %b want 000", {bus.m_cmd_valid, bus.m_cmd_we, bus.m_wvalid}); end
            vectors++; if ({bus.m_cmd_addr, bus.m_wdata, bus.rdata} !== '0) begin miscompares++; $display("FAIL rst_buses: addr %h wdata %h rdata %h want 0", bus.m_cmd_addr, bus.m_wdata, bus.rdata); end
            to_next();
        end
        RESET = 1'b0;
        drive_quiet();
    endtask

    task automatic test_read_req0();
        apply_reset();
        bus.req = 2'b01; bus.req_we = 2'b00; bus.req_addr = {15'h7FFF, 15'h1234};
        @(negedge CLK);
        vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL rd_idle_gnt: got %b want 00", bus.gnt); end
        to_next();
        bus.m_cmd_ready = 1'b1; bus.req = 2'b00;
        @(negedge CLK);
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL rd_gnt: got %b want 01", bus.gnt); end
        vectors++; if ({bus.m_cmd_valid, bus.m_cmd_we} !== 2'b10) begin miscompares++; $display("FAIL rd_cmd: valid/we got %b want 10", {bus.m_cmd_valid, bus.m_cmd_we}); end
        vectors++; if (bus.m_cmd_addr !== 15'h1234) begin miscompares++; $display("FAIL rd_addr: got %h want 1234", bus.m_cmd_addr); end
        to_next();
        bus.m_cmd_ready = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = DW'(16'h00A0 + i);
            @(negedge CLK);
            vectors++; if (bus.rvalid !== ((i == 0) ? 2'b00 : 2'b01)) begin miscompares++; $display("FAIL rd_rvalid beat %0d: got %b", i, bus.rvalid); end
            if (i > 0) begin
                vectors++; if (bus.rdata !== DW'(16'h00A0 + i - 1)) begin miscompares++; $display("FAIL rd_data beat %0d: got %h want %h", i - 1, bus.rdata, 16'h00A0 + i - 1); end
            end
            vectors++; if (bus.done !== 2'b00) begin miscompares++; $display("FAIL rd_early_done: got %b want 00", bus.done); end
            to_next();
        end
        bus.m_rvalid = 1'b0;
        @(negedge CLK);
        vectors++; if ({bus.rvalid, bus.done, bus.gnt} !== 6'b010101) begin miscompares++; $display("FAIL rd_last: rvalid/done/gnt got %b want 010101", {bus.rvalid, bus.done, bus.gnt}); end
        vectors++; if (bus.rdata !== 16'h00A7) begin miscompares++; $display("FAIL rd_last_data: got %h want 00a7", bus.rdata); end
        to_next();
        @(negedge CLK);
        vectors++; if ({bus.gnt, bus.done, bus.rvalid} !== 6'b000000) begin miscompares++; $display("FAIL rd_after: gnt/done/rvalid got %b want 000000", {bus.gnt, bus.done, bus.rvalid}); end
        to_next();
    endtask

    task automatic test_write_req1_stalls();
        logic [DW-1:0]  wb[BEATS];
        logic [LAW-1:0] a;
        int acks, wcyc, k;
        apply_reset();
        for (int i = 0; i < BEATS; i++) wb[i] = DW'($urandom);
        a = LAW'($urandom);
        bus.req = 2'b10; bus.req_we = 2'b10; bus.req_addr = {a, 15'h0}; bus.req_wdata = {wb[0], 16'h0};
        @(negedge CLK);
        to_next();
        bus.m_cmd_ready = 1'b1;
        @(negedge CLK);
        vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("FAIL wr_gnt: got %b want 10", bus.gnt); end
        vectors++; if ({bus.m_cmd_valid, bus.m_cmd_we} !== 2'b11) begin miscompares++; $display("FAIL wr_cmd: valid/we got %b want 11", {bus.m_cmd_valid, bus.m_cmd_we}); end
        vectors++; if (bus.m_cmd_addr !== a) begin miscompares++; $display("FAIL wr_addr: got %h want %h", bus.m_cmd_addr, a); end
        to_next();
        bus.m_cmd_ready = 1'b0; bus.req = 2'b00;
        acks = 0; wcyc = 0; k = 0;
        while (acks < BEATS && k < 40) begin
            bus.m_wready = (k % 2 == 0);
            bus.req_wdata[2*DW-1:DW] = wb[acks];
            @(negedge CLK);
            vectors++; if (bus.m_wvalid !== 1'b1) begin miscompares++; $display("FAIL wr_wvalid cyc %0d: got %b want 1", k, bus.m_wvalid); end
            vectors++; if (bus.m_wdata !== wb[acks]) begin miscompares++; $display("FAIL wr_wdata beat %0d: got %h want %h", acks, bus.m_wdata, wb[acks]); end
            vectors++; if (bus.wbeat_ack !== (bus.m_wready ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL wr_ack cyc %0d: got %b want %b", k, bus.wbeat_ack, bus.m_wready ? 2'b10 : 2'b00); end
            if (bus.m_wvalid === 1'b1) wcyc++;
            if (bus.m_wready) acks++;
            k++;
            to_next();
        end
        vectors++; if (acks != BEATS) begin miscompares++; $display("FAIL wr_timeout: acks %0d want %0d", acks, BEATS); end
        bus.m_wready = 1'b1;
        @(negedge CLK);
        vectors++; if ({bus.done, bus.gnt, bus.wbeat_ack, bus.m_wvalid} !== 7'b1010000) begin miscompares++; $display("FAIL wr_done: done/gnt/ack/wvalid got %b want 1010000", {bus.done, bus.gnt, bus.wbeat_ack, bus.m_wvalid}); end
        vectors++; if (wcyc != 15) begin miscompares++; $display("FAIL wr_cycles: got %0d want 15", wcyc); end
        to_next();
        bus.m_wready = 1'b0;
        @(negedge CLK);
        vectors++; if ({bus.gnt, bus.done} !== 4'b0000) begin miscompares++; $display("FAIL wr_after: gnt/done got %b want 0000", {bus.gnt, bus.done}); end
        to_next();
    endtask

    // Always-ready memory: each read transaction is 1 CMD + BEATS data + 1 DONE cycle, then 1 IDLE.
    task automatic test_tie_alternation();
        logic [1:0] eg, ed;
        apply_reset();
        bus.req = 2'b11; bus.req_addr = {LAW'($urandom), LAW'($urandom)};
        bus.m_cmd_ready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = DW'($urandom);
        for (int c = 0; c < 3 * (BEATS + 3); c++) begin
            eg = (c % (BEATS + 3) == 0) ? 2'b00 : (((c / (BEATS + 3)) % 2 == 0) ? 2'b01 : 2'b10);
            ed = (c % (BEATS + 3) == BEATS + 2) ? eg : 2'b00;
            @(negedge CLK);
            vectors++; if ({bus.gnt, bus.done} !== {eg, ed}) begin miscompares++; $display("FAIL tie cyc %0d: gnt/done got %b want %b", c, {bus.gnt, bus.done}, {eg, ed}); end
            to_next();
        end
        drive_quiet();
    endtask

    task automatic test_back_to_back();
        logic [1:0] eg;
        apply_reset();
        bus.req = 2'b01; bus.req_addr = {LAW'($urandom), LAW'($urandom)};
        bus.m_cmd_ready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = DW'($urandom);
        for (int c = 0; c < 3 * (BEATS + 3); c++) begin
            eg = (c % (BEATS + 3) == 0) ? 2'b00 : 2'b01;
            @(negedge CLK);
            vectors++; if (bus.gnt !== eg) begin miscompares++; $display("FAIL b2b cyc %0d: gnt got %b want %b", c, bus.gnt, eg); end
            to_next();
        end
        drive_quiet();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        bus.req = 2'b01;
        @(negedge CLK);
        to_next();
        bus.m_cmd_ready = 1'b1; bus.req = 2'b00;
        @(negedge CLK);
        to_next();
        bus.m_cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.m_rvalid = 1'b1; bus.m_rdata = DW'(16'h0C00 + i);
            @(negedge CLK);
            to_next();
        end
        RESET = 1'b1;
        @(negedge CLK);
        vectors++; if ({bus.rvalid, bus.rdata} !== {2'b01, 16'h0C02}) begin miscompares++; $display("FAIL mid_third_beat: rvalid %b rdata %h want 01 0c02", bus.rvalid, bus.rdata); end
        to_next();
        RESET = 1'b0; bus.m_rvalid = 1'b0; bus.req = 2'b11;
        @(negedge CLK);
        vectors++; if ({bus.gnt, bus.done, bus.rvalid, bus.m_cmd_valid} !== 7'b0000000) begin miscompares++; $display("FAIL mid_abort: gnt/done/rvalid/cmd got %b want 0000000", {bus.gnt, bus.done, bus.rvalid, bus.m_cmd_valid}); end
        to_next();
        @(negedge CLK);
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL mid_regrant: got %b want 01", bus.gnt); end
        to_next();
        apply_reset();
    endtask

    task automatic test_spurious_idle();
        apply_reset();
        bus.m_rvalid = 1'b1; bus.m_wready = 1'b1; bus.m_cmd_ready = 1'b1; bus.m_rdata = 16'hFFFF;
        bus.req_we = 2'b11; bus.req_addr = '1; bus.req_wdata = '1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            vectors++; if ({bus.gnt, bus.done, bus.rvalid, bus.wbeat_ack, bus.m_cmd_valid, bus.m_cmd_we, bus.m_wvalid} !== 11'h0) begin miscompares++; $display("FAIL spur_ctrl cyc %0d: got %b want 0", c, {bus.gnt, bus.done, bus.rvalid, bus.wbeat_ack, bus.m_cmd_valid, bus.m_cmd_we, bus.m_wvalid}); end
            vectors++; if ({bus.rdata, bus.m_wdata, bus.m_cmd_addr} !== '0) begin miscompares++; $display("FAIL spur_data cyc %0d: rdata %h wdata %h addr %h want 0", c, bus.rdata, bus.m_wdata, bus.m_cmd_addr); end
            to_next();
        end
        bus.req = 2'b01;
        @(negedge CLK);
        to_next();
        @(negedge CLK);
        vectors++; if ({bus.gnt, bus.m_cmd_valid} !== 3'b011) begin miscompares++; $display("FAIL spur_still_idle: gnt/cmd got %b want 011", {bus.gnt, bus.m_cmd_valid}); end
        to_next();
        apply_reset();
    endtask

    // Model phases: 0 waiting, 1 command, 2 write beats, 3 read beats, 4 completion.
    task automatic test_random(input int ncyc);
        logic           pend[2];
        logic           rwe[2];
        logic [LAW-1:0] raddr[2];
        logic [DW-1:0]  rwb[2][BEATS];
        int             ridx[2];
        logic [1:0]     rq;
        int             phase, mw, mlast, mbeats, mem_left, ntxn, c;
        logic           mwe, rv_next;
        logic [LAW-1:0] maddr;
        logic [DW-1:0]  rv_data;
        logic [1:0]     oh;
        apply_reset();
        for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; ridx[i] = 0; end
        phase = 0; mw = 0; mlast = 1; mbeats = 0; mem_left = 0; ntxn = 0;
        mwe = 1'b0; maddr = '0; rv_next = 1'b0; rv_data = '0;
        for (c = 0; c < ncyc + 400; c++) begin
            if (c >= ncyc && phase == 0 && !pend[0] && !pend[1]) break;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && c < ncyc && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1; rwe[i] = 1'($urandom_range(0, 1)); raddr[i] = LAW'($urandom); ridx[i] = 0;
                    for (int b = 0; b < BEATS; b++) rwb[i][b] = DW'($urandom);
                end
                rq[i] = pend[i];
                if (pend[i] && bus.gnt[i] && $urandom_range(0, 1) == 0) rq[i] = 1'b0;
            end
            bus.req       = rq;
            bus.req_we    = {rwe[1], rwe[0]};
            bus.req_addr  = {raddr[1], raddr[0]};
            bus.req_wdata = {rwb[1][(ridx[1] < BEATS) ? ridx[1] : 0], rwb[0][(ridx[0] < BEATS) ? ridx[0] : 0]};
            bus.m_cmd_ready = 1'($urandom_range(0, 1));
            bus.m_wready    = 1'($urandom_range(0, 1));
            bus.m_rvalid    = (mem_left > 0) && ($urandom_range(0, 2) != 0);
            bus.m_rdata     = DW'($urandom);
            @(negedge CLK);
            oh = (mw == 1) ? 2'b10 : 2'b01;
            vectors++; if (bus.gnt !== ((phase == 0) ? 2'b00 : oh)) begin miscompares++; $display("FAIL rnd_gnt cyc %0d: got %b want %b", c, bus.gnt, (phase == 0) ? 2'b00 : oh); end
            vectors++; if (bus.done !== ((phase == 4) ? oh : 2'b00)) begin miscompares++; $display("FAIL rnd_done cyc %0d: got %b want %b", c, bus.done, (phase == 4) ? oh : 2'b00); end
            vectors++; if ({bus.m_cmd_valid, bus.m_wvalid} !== {phase == 1, phase == 2}) begin miscompares++; $display("FAIL rnd_valids cyc %0d: cmd/w got %b phase %0d", c, {bus.m_cmd_valid, bus.m_wvalid}, phase); end
            if (phase == 1) begin
                vectors++; if ({bus.m_cmd_we, bus.m_cmd_addr} !== {mwe, maddr}) begin miscompares++; $display("FAIL rnd_cmd cyc %0d: we/addr got %b/%h want %b/%h", c, bus.m_cmd_we, bus.m_cmd_addr, mwe, maddr); end
            end
            if (phase == 2) begin
                vectors++; if (bus.m_wdata !== rwb[mw][mbeats]) begin miscompares++; $display("FAIL rnd_wdata cyc %0d: got %h want %h", c, bus.m_wdata, rwb[mw][mbeats]); end
            end
            vectors++; if (bus.wbeat_ack !== ((phase == 2 && bus.m_wready) ? oh : 2'b00)) begin miscompares++; $display("FAIL rnd_ack cyc %0d: got %b", c, bus.wbeat_ack); end
            vectors++; if (bus.rvalid !== (rv_next ? oh : 2'b00)) begin miscompares++; $display("FAIL rnd_rvalid cyc %0d: got %b want %b", c, bus.rvalid, rv_next ? oh : 2'b00); end
            if (rv_next) begin
                vectors++; if (bus.rdata !== rv_data) begin miscompares++; $display("FAIL rnd_rdata cyc %0d: got %h want %h", c, bus.rdata, rv_data); end
            end
            rv_next = 1'b0;
            case (phase)
                0: if (rq != 2'b00) begin
                       mw = (rq == 2'b01) ? 0 : (rq == 2'b10) ? 1 : 1 - mlast;
                       mlast = mw; mwe = rwe[mw]; maddr = raddr[mw]; phase = 1;
                   end
                1: if (bus.m_cmd_ready) begin phase = mwe ? 2 : 3; mbeats = 0; end
                2: if (bus.m_wready) begin mbeats++; if (mbeats == BEATS) phase = 4; end
                3: if (bus.m_rvalid) begin
                       rv_next = 1'b1; rv_data = bus.m_rdata; mbeats++;
                       if (mbeats == BEATS) phase = 4;
                   end
                default: begin phase = 0; ntxn++; end
            endcase
            for (int i = 0; i < 2; i++) begin
                if (bus.wbeat_ack[i]) ridx[i]++;
                if (bus.done[i]) pend[i] = 1'b0;
            end
            if (bus.m_rvalid) mem_left--;
            if (bus.m_cmd_valid && bus.m_cmd_ready && !bus.m_cmd_we) mem_left = BEATS;
            to_next();
        end
        vectors++; if (phase != 0 || pend[0] || pend[1]) begin miscompares++; $display("FAIL rnd_drain: phase %0d pend %b%b after %0d cycles", phase, pend[1], pend[0], c); end
        vectors++; if (ntxn < 20) begin miscompares++; $display("FAIL rnd_progress: %0d transactions completed, want at least 20", ntxn); end
        drive_quiet();
    endtask

    initial begin
        RESET = 1'b1;
        drive_quiet();
        to_next();
        test_reset();
        test_read_req0();
        test_write_req1_stalls();
        test_tie_alternation();
        test_back_to_back();
        test_reset_mid_read();
        test_spurious_idle();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-port round-robin arbiter and burst sequencer placed in front of the memory controller.
- Lets two cache-side requesters (e.g. instruction and data cache) share one memory port.
- Each granted transaction is a full line read or line write, moved as BEATS data beats.
- Command and data handshakes are owned by this block; requesters see only grant, beat strobes and a done pulse.

Parameters:
LINE_ADDR_W, 15, width of a line address (byte address without offset bits)
DATA_W, 16, width of one data beat
BEATS, 8, beats per line (16-byte line / 2-byte beat); must be >= 1

Ports:
CLK  input  1  clock
RESET  input  1  reset
req  input  2  per-requester transaction request, level
req_we  input  2  per-requester: 1 = line write, 0 = line read
req_addr  input  2*LINE_ADDR_W  packed line addresses, requester i at [i*LINE_ADDR_W +: LINE_ADDR_W]
req_wdata  input  2*DATA_W  packed current write beats, requester i at [i*DATA_W +: DATA_W]
gnt  output  2  one-hot grant, held for the whole transaction
wbeat_ack  output  2  write beat consumed; requester advances to next beat
rvalid  output  2  read beat valid for granted requester
rdata  output  DATA_W  read beat data, shared by both requesters
done  output  2  one-cycle transaction-complete pulse
m_cmd_valid  output  1  command to memory valid
m_cmd_we  output  1  command type
m_cmd_addr  output  LINE_ADDR_W  command line address
m_cmd_ready  input  1  memory accepts command
m_wvalid  output  1  write beat valid
m_wdata  output  DATA_W  write beat data
m_wready  input  1  memory accepts write beat
m_rvalid  input  1  memory read beat valid
m_rdata  input  DATA_W  memory read beat data

Behaviour:
- Clock and reset: single clock CLK; RESET is synchronous, active-high.
- Reset state: all outputs 0; FSM in IDLE; beat counter 0; last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, CMD, WDATA, RDATA, DONE.
- IDLE:
  - If any req is high, pick the winner: the sole requester, or on a tie the one not equal to last_grant.
  - Register winner index, req_we[w] and req_addr[w]; set last_grant = w.
  - Go to CMD; gnt[w] rises on entry to CMD.
- CMD:
  - m_cmd_valid = 1, with m_cmd_we and m_cmd_addr taken from the registered values.
  - On m_cmd_ready: clear the beat counter, then go to WDATA if we, else RDATA.
- WDATA:
  - m_wvalid = 1; m_wdata = req_wdata of the winner, passed through combinationally.
  - wbeat_ack[w] = m_wready in the same cycle.
  - Each accepted beat increments the counter; on beat BEATS-1 accepted, go to DONE.
- RDATA:
  - Each m_rvalid is registered: rdata <= m_rdata and rvalid[w] <= 1 for one cycle, so latency is 1 cycle.
  - Count beats; on the BEATS-th m_rvalid, go to DONE. The last rvalid pulse coincides with the DONE cycle.
- DONE:
  - done[w] = 1 for exactly one cycle; gnt[w] is still high.
  - Next cycle: gnt = 0, back to IDLE.
  - A request still high in IDLE is treated as a new request.
- Minimum transaction overhead: IDLE→CMD 1 cycle, plus DONE 1 cycle.
- gnt, done, rvalid and wbeat_ack are always one-hot or zero, and only ever asserted for the winner.
- m_rvalid outside RDATA and m_wready outside WDATA are ignored.
- m_cmd_ready outside CMD is ignored.
- req dropping mid-transaction is ignored; the transaction completes.
- req_addr and req_we changes after the IDLE sample are ignored.
- Memory stalls (ready or valid low) hold state indefinitely; there is no timeout.
- Beat counter width is max(1,$clog2(BEATS)). With BEATS=1, a single beat goes straight to DONE.
- RESET asserted in any state aborts the transaction: next cycle all outputs are 0 and the FSM is in IDLE; no done pulse is issued.

Test Plan:
- Read, requester 0: req=01, req_we=0, addr=0x1234. Memory asserts m_cmd_ready in the 1st CMD cycle and returns m_rdata 0xA0..0xA7 on 8 consecutive cycles. Required: m_cmd_addr=0x1234, m_cmd_we=0; rvalid[0] 8 pulses with rdata 0xA0..0xA7, each lagging m_rvalid by 1 cycle; done[0] with the last beat; gnt=00 next cycle.
- Write, requester 1 with stalls: req=10, req_we=1; m_wready toggles 1,0,1,0... Required: exactly 8 wbeat_ack[1] pulses, m_wdata matching req_wdata[31:16] at each; done[1] 1 cycle after the 8th ack; total WDATA cycles = 15.
- Tie after reset: req=11 from the first cycle. Required: gnt=01 first; after done[0] with req still 11, gnt=10; then gnt=01 again (strict alternation).
- Single requester repeating: req=01 held across 3 transactions. Required: 3 back-to-back grants to requester 0, each separated by exactly one IDLE cycle.
- Reset mid-read: RESET asserted after the 3rd read beat. Required: next cycle gnt=00, done=00, rvalid=00, m_cmd_valid=0. Later req=11 grants requester 0 first.
- Spurious memory signals in IDLE: m_rvalid=1, m_wready=1, m_cmd_ready=1 with req=00. Required: all outputs remain 0 and the FSM stays in IDLE.
